// File: rtl/apb_rx_ctrl_if.sv
// APB bus bundle for the UART receive register controller.
// The master drives the request fields; the slave returns read data and error.
interface apb_rx_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/apb_rx_ctrl.sv
// APB register controller for the UART receive block.
// Holds bit_period/data_size configuration, sticky receive errors and
// generates the one-cycle data_read acknowledge. Zero-wait-state slave.
//
// state_reg holds the bus phase of the previous cycle; state_next is the
// phase of the current cycle, so reads, errors and writes act in the same
// cycle the master presents its access phase.
module apb_rx_ctrl #(
  parameter logic [13:0] DEFAULT_BIT_PERIOD = 14'd10,
  parameter logic [3:0]  DEFAULT_DATA_SIZE  = 4'd8
) (
  input  logic               clk,
  input  logic               n_rst,
  apb_rx_ctrl_if.slave       apb,
  input  logic [7:0]         rx_data,
  input  logic               data_ready,
  input  logic               overrun_error,
  input  logic               framing_error,
  output logic               data_read,
  output logic [13:0]        bit_period,
  output logic [3:0]         data_size
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_reg, state_next;
  logic [13:0] bit_period_reg;
  logic [3:0]  data_size_reg;
  logic        framing_sticky_reg;
  logic        overrun_sticky_reg;
  logic        data_read_reg;

  logic        in_access;
  logic        violation;
  logic        access_err;
  logic        wr_ok;
  logic        rd_ok;
  logic        sticky_clr;
  logic [7:0]  read_data;
  logic [7:0]  rx_masked;
  logic [7:0]  prdata_next;
  logic        pslverr_next;

  // Bus phase register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Phase of the current cycle from previous phase and bus controls
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE: begin
        // psel & penable straight from IDLE is a protocol violation: stay IDLE
        if (apb.psel && !apb.penable) state_next = SETUP;
      end
      SETUP: begin
        if (apb.psel && apb.penable) state_next = ACCESS;
        else if (apb.psel)           state_next = SETUP;
      end
      ACCESS: begin
        if (apb.psel && !apb.penable) state_next = SETUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Receive byte trimmed to the configured frame width
  always_comb begin
    case (data_size_reg)
      4'd5:    rx_masked = {3'b000, rx_data[4:0]};
      4'd7:    rx_masked = {1'b0, rx_data[6:0]};
      default: rx_masked = rx_data;
    endcase
  end

  // Output decode: read mux, error response and register strobes
  always_comb begin
    in_access  = (state_next == ACCESS);
    violation  = (state_reg == IDLE) && apb.psel && apb.penable;
    read_data  = 8'h00;
    access_err = 1'b1;
    case (apb.paddr)
      3'd0: begin
        read_data  = {6'b0, framing_sticky_reg | overrun_sticky_reg, data_ready};
        access_err = apb.pwrite;
      end
      3'd1: begin
        read_data  = {6'b0, overrun_sticky_reg, framing_sticky_reg};
        access_err = apb.pwrite;
      end
      3'd2: begin
        read_data  = bit_period_reg[7:0];
        access_err = 1'b0;
      end
      3'd3: begin
        read_data  = {2'b00, bit_period_reg[13:8]};
        access_err = 1'b0;
      end
      3'd4: begin
        read_data  = {4'b0, data_size_reg};
        access_err = apb.pwrite && !(apb.pwdata[3:0] == 4'd5 ||
                                     apb.pwdata[3:0] == 4'd7 ||
                                     apb.pwdata[3:0] == 4'd8);
      end
      3'd6: begin
        read_data  = rx_masked;
        access_err = apb.pwrite;
      end
      default: begin
        read_data  = 8'h00;
        access_err = 1'b1;
      end
    endcase
    wr_ok        = in_access && apb.pwrite && !access_err;
    rd_ok        = in_access && !apb.pwrite && !access_err;
    sticky_clr   = rd_ok && (apb.paddr == 3'd1);
    prdata_next  = apb.psel ? read_data : 8'h00;
    pslverr_next = (in_access && access_err) || violation;
  end

  assign apb.prdata  = prdata_next;
  assign apb.pslverr = pslverr_next;

  // Configuration registers, written at the edge ending an error-free access
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_period_reg <= DEFAULT_BIT_PERIOD;
      data_size_reg  <= DEFAULT_DATA_SIZE;
    end else if (wr_ok) begin
      case (apb.paddr)
        3'd2:    bit_period_reg[7:0]  <= apb.pwdata;
        3'd3:    bit_period_reg[13:8] <= apb.pwdata[5:0];
        3'd4:    data_size_reg        <= apb.pwdata[3:0];
        default: ;
      endcase
    end
  end

  // Sticky receive errors: a new error in the clearing cycle wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_sticky_reg <= 1'b0;
      overrun_sticky_reg <= 1'b0;
    end else begin
      framing_sticky_reg <= framing_error | (framing_sticky_reg & ~sticky_clr);
      overrun_sticky_reg <= overrun_error | (overrun_sticky_reg & ~sticky_clr);
    end
  end

  // One-cycle acknowledge after each good read of the receive byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) data_read_reg <= 1'b0;
    else        data_read_reg <= rd_ok && (apb.paddr == 3'd6) && data_ready;
  end

  assign data_read  = data_read_reg;
  assign bit_period = bit_period_reg;
  assign data_size  = data_size_reg;

endmodule

// File: tb/tb_apb_rx_ctrl.sv
// Testbench for apb_rx_ctrl: table of APB transfers plus hand-written
// sequences for data_read pulses, sticky errors, protocol violation and reset.
module tb_apb_rx_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'hFF;
  logic        data_ready = 1'b0;
  logic        overrun_error = 1'b0;
  logic        framing_error = 1'b0;
  logic        data_read;
  logic [13:0] bit_period;
  logic [3:0]  data_size;

  int tests = 0;
  int fails = 0;

  apb_rx_ctrl_if bus ();

  apb_rx_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .apb          (bus),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .data_read    (data_read),
    .bit_period   (bit_period),
    .data_size    (data_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic        exp_err;
    logic [13:0] exp_bp;
    logic [3:0]  exp_ds;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Two-phase APB transfer; returns at the negedge after ACCESS with the bus idle
  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wd;
    #1 check("setup_pslverr", {31'b0, bus.pslverr}, 32'd0);
    @(negedge clk);
    bus.penable = 1'b1;
    #1 rd = bus.prdata; err = bus.pslverr;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       err;

    vecs[0]  = '{1'b0, 3'd2, 8'h00, 8'h0A, 1'b0, 14'd10,    4'd8};
    vecs[1]  = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 14'd10,    4'd8};
    vecs[2]  = '{1'b0, 3'd4, 8'h00, 8'h08, 1'b0, 14'd10,    4'd8};
    vecs[3]  = '{1'b1, 3'd2, 8'h34, 8'h00, 1'b0, 14'h0034,  4'd8};
    vecs[4]  = '{1'b1, 3'd3, 8'hFF, 8'h00, 1'b0, 14'h3F34,  4'd8};
    vecs[5]  = '{1'b0, 3'd3, 8'h00, 8'h3F, 1'b0, 14'h3F34,  4'd8};
    vecs[6]  = '{1'b0, 3'd2, 8'h00, 8'h34, 1'b0, 14'h3F34,  4'd8};
    vecs[7]  = '{1'b1, 3'd4, 8'h06, 8'h00, 1'b1, 14'h3F34,  4'd8};
    vecs[8]  = '{1'b1, 3'd4, 8'h07, 8'h00, 1'b0, 14'h3F34,  4'd7};
    vecs[9]  = '{1'b0, 3'd4, 8'h00, 8'h07, 1'b0, 14'h3F34,  4'd7};
    vecs[10] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 14'h3F34,  4'd7};
    vecs[11] = '{1'b1, 3'd0, 8'h55, 8'h00, 1'b1, 14'h3F34,  4'd7};
    vecs[12] = '{1'b1, 3'd6, 8'h00, 8'h00, 1'b1, 14'h3F34,  4'd7};
    vecs[13] = '{1'b0, 3'd6, 8'h00, 8'h7F, 1'b0, 14'h3F34,  4'd7};
    vecs[14] = '{1'b1, 3'd4, 8'h05, 8'h00, 1'b0, 14'h3F34,  4'd5};
    vecs[15] = '{1'b0, 3'd6, 8'h00, 8'h1F, 1'b0, 14'h3F34,  4'd5};
    vecs[16] = '{1'b1, 3'd4, 8'h08, 8'h00, 1'b0, 14'h3F34,  4'd8};
    vecs[17] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 14'h3F34,  4'd8};

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 3'd0; bus.pwdata = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_prdata",     {24'b0, bus.prdata}, 32'h00);
    check("rst_pslverr",    {31'b0, bus.pslverr}, 32'd0);
    check("rst_data_read",  {31'b0, data_read}, 32'd0);
    check("rst_bit_period", {18'b0, bit_period}, 32'd10);
    check("rst_data_size",  {28'b0, data_size}, 32'd8);
    n_rst = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < 18; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      #1;
      $display("[TB] vec %0d %s addr=%0d wdata=%02h prdata=%02h pslverr=%0b bit_period=%04h data_size=%0d",
               i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, rd, err, bit_period, data_size);
      if (!vecs[i].wr) check($sformatf("vec%0d_prdata", i), {24'b0, rd}, {24'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_bit_period", i), {18'b0, bit_period}, {18'b0, vecs[i].exp_bp});
      check($sformatf("vec%0d_data_size", i), {28'b0, data_size}, {28'b0, vecs[i].exp_ds});
      check($sformatf("vec%0d_data_read", i), {31'b0, data_read}, 32'd0);
    end

    // Single read of addr 6 with data_ready: one-cycle data_read pulse
    apb_xfer(1'b1, 3'd4, 8'h07, rd, err);
    data_ready = 1'b1;
    apb_xfer(1'b0, 3'd6, 8'h00, rd, err);
    #1;
    $display("[TB] read6 prdata=%02h pslverr=%0b data_read=%0b", rd, err, data_read);
    check("rd6_prdata", {24'b0, rd}, 32'h7F);
    check("rd6_pulse", {31'b0, data_read}, 32'd1);
    @(negedge clk); #1;
    check("rd6_pulse_end", {31'b0, data_read}, 32'd0);

    // Back-to-back reads of addr 6: two separate pulses
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 3'd6;
    @(negedge clk);
    bus.penable = 1'b1;
    #1 check("b2b_prdata1", {24'b0, bus.prdata}, 32'h7F);
    @(negedge clk);
    bus.penable = 1'b0;
    #1 check("b2b_pulse1", {31'b0, data_read}, 32'd1);
    @(negedge clk);
    bus.penable = 1'b1;
    #1 check("b2b_gap", {31'b0, data_read}, 32'd0);
    check("b2b_pslverr2", {31'b0, bus.pslverr}, 32'd0);
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1 check("b2b_pulse2", {31'b0, data_read}, 32'd1);
    @(negedge clk); #1;
    check("b2b_pulse2_end", {31'b0, data_read}, 32'd0);
    $display("[TB] back-to-back read6 done");

    // Sticky framing error
    data_ready = 1'b0;
    @(negedge clk); framing_error = 1'b1;
    @(negedge clk); framing_error = 1'b0;
    apb_xfer(1'b0, 3'd0, 8'h00, rd, err);
    $display("[TB] status addr0 prdata=%02h", rd);
    check("status_framing", {24'b0, rd}, 32'h02);
    data_ready = 1'b1;
    apb_xfer(1'b0, 3'd0, 8'h00, rd, err);
    $display("[TB] status addr0 (ready) prdata=%02h", rd);
    check("status_framing_ready", {24'b0, rd}, 32'h03);
    data_ready = 1'b0;
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    $display("[TB] errors addr1 prdata=%02h", rd);
    check("err_framing", {24'b0, rd}, 32'h01);
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    $display("[TB] errors addr1 after clear prdata=%02h", rd);
    check("err_cleared", {24'b0, rd}, 32'h00);

    // Overrun held high across clearing reads: set wins
    @(negedge clk); overrun_error = 1'b1;
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    check("err_overrun", {24'b0, rd}, 32'h02);
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    $display("[TB] errors addr1 overrun held prdata=%02h", rd);
    check("err_overrun_held", {24'b0, rd}, 32'h02);
    overrun_error = 1'b0;
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    check("err_overrun_last", {24'b0, rd}, 32'h02);
    apb_xfer(1'b0, 3'd1, 8'h00, rd, err);
    $display("[TB] errors addr1 overrun released prdata=%02h", rd);
    check("err_overrun_cleared", {24'b0, rd}, 32'h00);

    // psel & penable from IDLE: error, no write
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 3'd2; bus.pwdata = 8'h99;
    #1 check("idle_violation_err", {31'b0, bus.pslverr}, 32'd1);
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    #1 check("idle_violation_bp", {18'b0, bit_period}, 32'h3F34);
    $display("[TB] idle violation bit_period=%04h", bit_period);

    // Reset during the ACCESS of a write to addr 2
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 3'd2; bus.pwdata = 8'h55;
    @(negedge clk);
    bus.penable = 1'b1;
    #2 n_rst = 1'b0;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    n_rst = 1'b1;
    #1;
    $display("[TB] mid-transfer reset bit_period=%0d data_size=%0d data_read=%0b",
             bit_period, data_size, data_read);
    check("midrst_bp", {18'b0, bit_period}, 32'd10);
    check("midrst_ds", {28'b0, data_size}, 32'd8);
    check("midrst_data_read", {31'b0, data_read}, 32'd0);
    // Only an FSM in IDLE flags psel & penable as a violation
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 3'd2;
    #1 check("midrst_idle", {31'b0, bus.pslverr}, 32'd1);
    check("midrst_prdata", {24'b0, bus.prdata}, 32'h0A);
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1 check("midrst_data_read2", {31'b0, data_read}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
